// File: rtl/uart_frame_pkg.sv
// uart_frame_pkg: shared types and helpers for the framed UART transmitter.
//   frame_state_t : frame FSM states (IDLE, SYNC, OPT, LEN, DATA, CRC)
//   CRC_*         : CRC-32 (IEEE, reflected) constants
//   crc32_byte    : bytewise reflected CRC-32 update
package uart_frame_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    OPT,
    LEN,
    DATA,
    CRC
  } frame_state_t;

  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB8_8320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_XOROUT    = 32'hFFFF_FFFF;

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int unsigned i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: one-character UART serializer with built-in baud timer.
// Character = start bit (0), 8 data bits LSB first, STOP_BITS stop bits (1).
// A new byte may be accepted on the same edge the previous character ends,
// so consecutive characters are sent with no idle gap.
// Ports:
//   CLK, RST    clock, synchronous active-low reset
//   byte_data   byte to send
//   byte_valid  byte offered
//   byte_ready  serializer can take a byte this cycle
//   char_end    high in the last cycle of the last stop bit
//   out_bit     registered serial line, idle 1
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 868,
  parameter int STOP_BITS    = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] byte_data,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       char_end,
  output logic       out_bit
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    LAST_BIT   = 4'(8 + STOP_BITS);

  logic [TW-1:0] timer;
  logic [3:0]    bit_idx;
  logic [7:0]    shifter;
  logic          active;
  logic          bit_end;

  assign bit_end    = active && (timer == TIMER_LAST);
  assign char_end   = bit_end && (bit_idx == LAST_BIT);
  assign byte_ready = !active || char_end;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      timer   <= '0;
      bit_idx <= '0;
      shifter <= '0;
      active  <= 1'b0;
      out_bit <= 1'b1;
    end else if (byte_valid && byte_ready) begin
      timer   <= '0;
      bit_idx <= '0;
      shifter <= byte_data;
      active  <= 1'b1;
      out_bit <= 1'b0;
    end else if (bit_end) begin
      timer <= '0;
      if (char_end) begin
        active  <= 1'b0;
        bit_idx <= '0;
        out_bit <= 1'b1;
      end else begin
        bit_idx <= bit_idx + 4'd1;
        // bit_idx 0..7 ending means data bit bit_idx starts next
        if (bit_idx < 4'd8) begin
          out_bit <= shifter[0];
          shifter <= shifter >> 1;
        end else begin
          out_bit <= 1'b1;
        end
      end
    end else if (active) begin
      timer <= timer + 1'b1;
    end
  end

endmodule

// File: rtl/uart_frame_tx.sv
// uart_frame_tx: framed UART transmitter.
// Wire order: SYNC_BYTE, OPT, LEN(clamped), payload[0..len_c-1], CRC[0..3].
// Optional feature macro: UART_FRAME_TX_CRC_EN (adds the CRC-32 trailer over
// OPT, LEN and payload; when undefined the frame ends after the payload).
// Ports:
//   CLK, RST    clock, synchronous active-low reset
//   full_data   payload, byte 0 in the top bits
//   opt, len    option byte, requested payload length
//   in_valid    frame offered; accepted when ready
//   ready/busy  IDLE / frame in flight
//   frame_done  one-cycle pulse at the end of the last stop bit
//   out_bit     serial line, idle 1
module uart_frame_tx
  import uart_frame_pkg::*;
#(
  parameter int          MAX_DATA_BYTES = 16,
  parameter int          BYTE_SIZE      = 8,
  parameter int          CLKS_PER_BIT   = 868,
  parameter int          STOP_BITS      = 1,
  parameter logic [7:0]  SYNC_BYTE      = 8'hFE
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic [MAX_DATA_BYTES*BYTE_SIZE-1:0] full_data,
  input  logic [7:0]                        opt,
  input  logic [7:0]                        len,
  input  logic                              in_valid,
  output logic                              ready,
  output logic                              busy,
  output logic                              frame_done,
  output logic                              out_bit
);

  localparam int         BW      = $clog2(MAX_DATA_BYTES + 1);
  localparam int         PW      = MAX_DATA_BYTES * BYTE_SIZE;
  localparam logic [7:0] MAX_LEN = 8'(MAX_DATA_BYTES);
`ifdef UART_FRAME_TX_CRC_EN
  localparam frame_state_t TAIL = CRC;
`else
  localparam frame_state_t TAIL = IDLE;
`endif

  frame_state_t    state, state_next, load_state;
  logic [PW-1:0]   payload, payload_shift;
  logic [7:0]      opt_q, len_q;
  logic [BW-1:0]   byte_idx, byte_idx_next;
  logic            sync_pend;
  logic            last_data;
  logic            char_end, byte_ready, byte_valid;
  logic [7:0]      byte_data;
`ifdef UART_FRAME_TX_CRC_EN
  logic [31:0]     crc, crc_out;
  logic [1:0]      crc_idx, crc_idx_next;
`endif

  assign ready = (state == IDLE);
  assign busy  = !ready;

  always_comb begin
    state_next    = state;
    byte_idx_next = byte_idx;
    last_data     = (8'(byte_idx) == (len_q - 8'd1));
`ifdef UART_FRAME_TX_CRC_EN
    crc_idx_next  = crc_idx;
`endif
    case (state)
      IDLE: if (in_valid) state_next = SYNC;
      SYNC: if (char_end) state_next = OPT;
      OPT:  if (char_end) state_next = LEN;
      LEN:  if (char_end) state_next = (len_q != 8'd0) ? DATA : TAIL;
      DATA: if (char_end) begin
        if (last_data) state_next = TAIL;
        else           byte_idx_next = byte_idx + 1'b1;
      end
`ifdef UART_FRAME_TX_CRC_EN
      CRC:  if (char_end) begin
        if (crc_idx == 2'd3) state_next = IDLE;
        else                 crc_idx_next = crc_idx + 2'd1;
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  // State tracks the character on the wire; the next character is loaded on
  // the edge the current one ends, so the mux selects by the upcoming state.
  // SYNC is the exception: it is loaded one edge after the handshake.
  always_comb begin
    load_state    = sync_pend ? SYNC : state_next;
    byte_valid    = sync_pend || (char_end && (state_next != IDLE));
    payload_shift = payload << (BYTE_SIZE * int'(byte_idx_next));
`ifdef UART_FRAME_TX_CRC_EN
    crc_out       = crc ^ CRC_XOROUT;
`endif
    case (load_state)
      OPT:     byte_data = opt_q;
      LEN:     byte_data = len_q;
      DATA:    byte_data = payload_shift[PW-1 -: 8];
`ifdef UART_FRAME_TX_CRC_EN
      CRC:     byte_data = crc_out[{crc_idx_next, 3'b000} +: 8];
`endif
      default: byte_data = SYNC_BYTE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state      <= IDLE;
      byte_idx   <= '0;
      sync_pend  <= 1'b0;
      frame_done <= 1'b0;
      payload    <= '0;
      opt_q      <= '0;
      len_q      <= '0;
`ifdef UART_FRAME_TX_CRC_EN
      crc        <= CRC_INIT;
      crc_idx    <= '0;
`endif
    end else begin
      state      <= state_next;
      byte_idx   <= byte_idx_next;
      frame_done <= (state != IDLE) && (state_next == IDLE);
`ifdef UART_FRAME_TX_CRC_EN
      crc_idx    <= crc_idx_next;
`endif
      if ((state == IDLE) && in_valid) begin
        payload   <= full_data;
        opt_q     <= opt;
        len_q     <= (len > MAX_LEN) ? MAX_LEN : len;
        sync_pend <= 1'b1;
        byte_idx  <= '0;
`ifdef UART_FRAME_TX_CRC_EN
        crc       <= CRC_INIT;
        crc_idx   <= '0;
`endif
      end else if (byte_valid && byte_ready) begin
        sync_pend <= 1'b0;
`ifdef UART_FRAME_TX_CRC_EN
        if (load_state inside {OPT, LEN, DATA})
          crc <= crc32_byte(crc, byte_data);
`endif
      end
    end
  end

  uart_tx_serializer #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .STOP_BITS    (STOP_BITS)
  ) u_ser (
    .CLK        (CLK),
    .RST        (RST),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .char_end   (char_end),
    .out_bit    (out_bit)
  );

endmodule
